// File: rtl/car_wave_scheduler.sv
// Enemy-car wave scheduler: paces spawns per stage, tracks occupied car slots, counts escapes into lives / game over.
// Latency: first spawn appears interval+1 cycles after the FSM leaves IDLE; mask and lives update one edge after an event.
// Backpressure: when every slot is occupied, the spawn timer holds at its terminal count until a kill or escape frees a slot.
module car_wave_scheduler #(
  parameter int SLOTS       = 8,
  parameter int TIMER_W     = 26,
  parameter int S1_CARS     = 4,
  parameter int S2_CARS     = 6,
  parameter int S3_CARS     = 8,
  parameter int S1_INTERVAL = 25_000_000,
  parameter int S2_INTERVAL = 20_000_000,
  parameter int S3_INTERVAL = 15_000_000,
  parameter int LIVES       = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stage_1_in_progress,
  input  logic                     stage_2_in_progress,
  input  logic                     stage_3_in_progress,
  input  logic                     car_killed,
  input  logic [$clog2(SLOTS)-1:0] car_killed_id,
  input  logic                     car_escaped,
  input  logic [$clog2(SLOTS)-1:0] car_escaped_id,
  output logic                     spawn,
  output logic [$clog2(SLOTS)-1:0] spawn_id,
  output logic [SLOTS-1:0]         active_mask,
  output logic [3:0]               lives_left,
  output logic                     stage_1_car_done,
  output logic                     stage_2_car_done,
  output logic                     stage_3_car_done,
  output logic                     game_over
);

  localparam int ID_W = $clog2(SLOTS);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_SPAWN = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_OVER  = 3'd6;

  localparam logic [3:0] LIVES_V = 4'(LIVES);

  logic [2:0]         state_q, state_d;
  logic [1:0]         stage_q, stage_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] interval_q, interval_d;
  logic [3:0]         to_spawn_q, to_spawn_d;
  logic [3:0]         escapes_q, escapes_d;
  logic [3:0]         lives_left_q, lives_left_d;
  logic [SLOTS-1:0]   active_mask_q, active_mask_d;

  logic               free_any;
  logic [ID_W-1:0]    free_id;
  logic               esc_hit, kill_hit, esc_cnt;
  logic [SLOTS-1:0]   clr_vec, set_vec;
  logic               stage_live, in_wave, abort;

  // Lowest-index free slot; scanning downward lets the last hit win.
  always_comb begin
    free_any = 1'b0;
    free_id  = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!active_mask_q[i]) begin
        free_any = 1'b1;
        free_id  = ID_W'(i);
      end
    end
  end

  // Kill/escape qualification: only occupied slots count, escape wins a same-slot tie.
  always_comb begin
    esc_hit  = car_escaped && active_mask_q[car_escaped_id];
    kill_hit = car_killed && active_mask_q[car_killed_id] &&
               !(car_escaped && (car_escaped_id == car_killed_id));
    // Escape counter saturates at LIVES so lives_left never wraps.
    esc_cnt  = esc_hit && (escapes_q != LIVES_V);
    clr_vec  = '0;
    if (esc_hit)  clr_vec[car_escaped_id] = 1'b1;
    if (kill_hit) clr_vec[car_killed_id]  = 1'b1;
  end

  // In-progress level of whichever stage was latched on leaving IDLE.
  always_comb begin
    case (stage_q)
      2'd1:    stage_live = stage_1_in_progress;
      2'd2:    stage_live = stage_2_in_progress;
      2'd3:    stage_live = stage_3_in_progress;
      default: stage_live = 1'b0;
    endcase
  end

  // Wave FSM with game-over and abort overrides for the active-wave states.
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    timer_d    = timer_q;
    interval_d = interval_q;
    to_spawn_d = to_spawn_q;
    set_vec    = '0;
    abort      = 1'b0;
    in_wave    = (state_q == ST_LOAD) || (state_q == ST_WAIT) ||
                 (state_q == ST_SPAWN) || (state_q == ST_DRAIN);

    case (state_q)
      ST_IDLE: begin
        if (stage_1_in_progress) begin
          stage_d    = 2'd1;
          to_spawn_d = 4'(S1_CARS);
          interval_d = TIMER_W'(S1_INTERVAL);
          state_d    = ST_LOAD;
        end else if (stage_2_in_progress) begin
          stage_d    = 2'd2;
          to_spawn_d = 4'(S2_CARS);
          interval_d = TIMER_W'(S2_INTERVAL);
          state_d    = ST_LOAD;
        end else if (stage_3_in_progress) begin
          stage_d    = 2'd3;
          to_spawn_d = 4'(S3_CARS);
          interval_d = TIMER_W'(S3_INTERVAL);
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (timer_q == interval_q - TIMER_W'(1)) begin
          // Terminal count: spawn if a slot is free, otherwise stall here.
          if (free_any) state_d = ST_SPAWN;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_SPAWN: begin
        set_vec[free_id] = 1'b1;
        to_spawn_d       = to_spawn_q - 4'd1;
        timer_d          = '0;
        state_d          = (to_spawn_q == 4'd1) ? ST_DRAIN : ST_WAIT;
      end
      ST_DRAIN: begin
        if (active_mask_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!stage_live) state_d = ST_IDLE;
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (in_wave) begin
      if (escapes_q == LIVES_V) begin
        state_d = ST_OVER;
      end else if (!stage_live) begin
        state_d    = ST_IDLE;
        to_spawn_d = '0;
        abort      = 1'b1;
      end
    end
  end

  // Slot occupancy and life counters.
  always_comb begin
    active_mask_d = abort ? '0 : ((active_mask_q & ~clr_vec) | set_vec);
    escapes_d     = escapes_q + 4'(esc_cnt);
    lives_left_d  = lives_left_q - 4'(esc_cnt);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      stage_q       <= 2'd0;
      timer_q       <= '0;
      interval_q    <= '0;
      to_spawn_q    <= '0;
      escapes_q     <= '0;
      lives_left_q  <= LIVES_V;
      active_mask_q <= '0;
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      timer_q       <= timer_d;
      interval_q    <= interval_d;
      to_spawn_q    <= to_spawn_d;
      escapes_q     <= escapes_d;
      lives_left_q  <= lives_left_d;
      active_mask_q <= active_mask_d;
    end
  end

  assign spawn            = (state_q == ST_SPAWN);
  assign spawn_id         = spawn ? free_id : '0;
  assign active_mask      = active_mask_q;
  assign lives_left       = lives_left_q;
  assign stage_1_car_done = (state_q == ST_DONE) && (stage_q == 2'd1);
  assign stage_2_car_done = (state_q == ST_DONE) && (stage_q == 2'd2);
  assign stage_3_car_done = (state_q == ST_DONE) && (stage_q == 2'd3);
  assign game_over        = (state_q == ST_OVER);

endmodule

// File: tb/tb_car_wave_scheduler.sv
// Bench for car_wave_scheduler: directed scenarios plus randomized kill/escape traffic
// checked against a spawn-timeline reference model.
module tb_car_wave_scheduler;

  localparam int C1 = 2, C2 = 5, C3 = 10;
  localparam int IV1 = 4, IV2 = 3, IV3 = 2;
  localparam int LV = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       s1, s2, s3;
  logic       kl, es;
  logic [2:0] kid, eid;
  logic       spawn;
  logic [2:0] spawn_id;
  logic [7:0] active_mask;
  logic [3:0] lives_left;
  logic       d1, d2, d3;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  car_wave_scheduler #(
    .SLOTS(8), .TIMER_W(26),
    .S1_CARS(C1), .S2_CARS(C2), .S3_CARS(C3),
    .S1_INTERVAL(IV1), .S2_INTERVAL(IV2), .S3_INTERVAL(IV3),
    .LIVES(LV)
  ) dut (
    .clk(clk), .reset(reset),
    .stage_1_in_progress(s1), .stage_2_in_progress(s2), .stage_3_in_progress(s3),
    .car_killed(kl), .car_killed_id(kid),
    .car_escaped(es), .car_escaped_id(eid),
    .spawn(spawn), .spawn_id(spawn_id),
    .active_mask(active_mask), .lives_left(lives_left),
    .stage_1_car_done(d1), .stage_2_car_done(d2), .stage_3_car_done(d3),
    .game_over(game_over)
  );

  // Reference model: slot occupancy array plus a countdown to the next spawn.
  bit m_act [8];
  int m_lives, m_left, m_eta, m_iv;
  bit m_spawning, m_drain, m_done;

  function automatic int m_lowfree();
    for (int i = 0; i < 8; i++) if (!m_act[i]) return i;
    return 0;
  endfunction

  function automatic bit m_anyfree();
    for (int i = 0; i < 8; i++) if (!m_act[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_anyact();
    for (int i = 0; i < 8; i++) if (m_act[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] m_mask();
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = m_act[i];
    return m;
  endfunction

  // Advance the model across one clock edge with the events currently driven.
  task automatic m_step(input bit k_v, input int k_id, input bit e_v, input int e_id);
    bit nact [8];
    nact = m_act;
    if (m_spawning) begin
      nact[m_lowfree()] = 1'b1;
      m_left--;
      m_spawning = 1'b0;
      if (m_left == 0) m_drain = 1'b1;
      else m_eta = m_iv;
    end else if (m_drain) begin
      if (!m_anyact()) begin
        m_done  = 1'b1;
        m_drain = 1'b0;
      end
    end else if (!m_done) begin
      if (m_eta > 1) m_eta--;
      else if (m_anyfree()) m_spawning = 1'b1;
    end
    if (e_v && m_act[e_id]) begin
      nact[e_id] = 1'b0;
      m_lives--;
    end
    if (k_v && m_act[k_id] && !(e_v && e_id == k_id)) nact[k_id] = 1'b0;
    m_act = nact;
  endtask

  task automatic clear_events();
    kl = 1'b0; es = 1'b0; kid = 3'd0; eid = 3'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
    clear_events();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_spawn(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (spawn === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
    clear_events();
    @(negedge clk);
    checks++; if (spawn !== 1'b0) begin errors++; $display("FAIL reset_spawn got %0b want 0", spawn); end
    checks++; if (active_mask !== 8'h00) begin errors++; $display("FAIL reset_mask got %h want 00", active_mask); end
    checks++; if (lives_left !== 4'(LV)) begin errors++; $display("FAIL reset_lives got %0d want %0d", lives_left, LV); end
    checks++; if ({d1, d2, d3, game_over} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {d1, d2, d3, game_over}); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({spawn, d1, d2, d3, game_over} !== 5'b0) begin errors++; $display("FAIL idle_quiet got %b want 00000", {spawn, d1, d2, d3, game_over}); end
  endtask

  task automatic test_stage1_timing();
    bit exp;
    do_reset();
    s1 = 1'b1;                       // sampled at edge 0
    for (int n = 0; n <= 11; n++) begin
      @(negedge clk);                // just after edge n
      exp = (n == 5) || (n == 10);
      checks++; if (spawn !== exp) begin errors++; $display("FAIL s1_spawn_e%0d got %0b want %0b", n, spawn, exp); end
      if (exp) begin
        checks++; if (spawn_id !== ((n == 5) ? 3'd0 : 3'd1)) begin errors++; $display("FAIL s1_id_e%0d got %0d want %0d", n, spawn_id, (n == 5) ? 0 : 1); end
      end
      if (n == 6) begin
        checks++; if (active_mask !== 8'h01) begin errors++; $display("FAIL s1_mask_e6 got %h want 01", active_mask); end
      end
    end
    checks++; if (active_mask !== 8'h03) begin errors++; $display("FAIL s1_mask_e11 got %h want 03", active_mask); end
    kl = 1'b1; kid = 3'd0;
    @(negedge clk);
    checks++; if (active_mask !== 8'h02) begin errors++; $display("FAIL s1_kill0 got %h want 02", active_mask); end
    kid = 3'd1;
    @(negedge clk);
    clear_events();
    checks++; if ({active_mask, d1} !== 9'h000) begin errors++; $display("FAIL s1_kill1 got %h/%0b want 00/0", active_mask, d1); end
    @(negedge clk);
    checks++; if (d1 !== 1'b1) begin errors++; $display("FAIL s1_done got %0b want 1", d1); end
    @(negedge clk);
    checks++; if (d1 !== 1'b1) begin errors++; $display("FAIL s1_done_hold got %0b want 1", d1); end
    s1 = 1'b0;
    @(negedge clk);
    checks++; if ({d1, spawn, active_mask} !== 10'h000) begin errors++; $display("FAIL s1_release got %b want 0", {d1, spawn, active_mask}); end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset();
    s3 = 1'b1;
    for (int s = 0; s < 8; s++) begin
      wait_spawn(ok);
      checks++; if (!ok || spawn_id !== 3'(s)) begin errors++; $display("FAIL stall_fill%0d got ok=%0b id=%0d want id %0d", s, ok, spawn_id, s); end
    end
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checks++; if (spawn !== 1'b0) begin errors++; $display("FAIL stall_hold%0d got %0b want 0", n, spawn); end
    end
    checks++; if (active_mask !== 8'hFF) begin errors++; $display("FAIL stall_full got %h want ff", active_mask); end
    kl = 1'b1; kid = 3'd3;
    @(negedge clk);
    clear_events();
    checks++; if ({spawn, active_mask} !== 9'h0F7) begin errors++; $display("FAIL stall_freed got %b want 011110111", {spawn, active_mask}); end
    @(negedge clk);
    checks++; if (spawn !== 1'b1 || spawn_id !== 3'd3) begin errors++; $display("FAIL stall_refill got %0b/%0d want 1/3", spawn, spawn_id); end
    @(negedge clk);
    checks++; if (active_mask !== 8'hFF) begin errors++; $display("FAIL stall_refull got %h want ff", active_mask); end
    s3 = 1'b0;
    @(negedge clk);
    checks++; if (active_mask !== 8'h00) begin errors++; $display("FAIL stall_abort got %h want 00", active_mask); end
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checks++; if (spawn !== 1'b0) begin errors++; $display("FAIL stall_quiet%0d got %0b want 0", n, spawn); end
    end
  endtask

  task automatic test_kill_escape();
    bit ok;
    do_reset();
    s2 = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_spawn(ok);
      checks++; if (!ok || spawn_id !== 3'(s)) begin errors++; $display("FAIL ke_spawn%0d got ok=%0b id=%0d want id %0d", s, ok, spawn_id, s); end
    end
    @(negedge clk);
    checks++; if (active_mask !== 8'h07) begin errors++; $display("FAIL ke_mask3 got %h want 07", active_mask); end
    kl = 1'b1; kid = 3'd2; es = 1'b1; eid = 3'd2;
    @(negedge clk);
    checks++; if (active_mask !== 8'h03 || lives_left !== 4'd2) begin errors++; $display("FAIL ke_same_id got %h/%0d want 03/2", active_mask, lives_left); end
    kid = 3'd5; eid = 3'd5;
    @(negedge clk);
    checks++; if (active_mask !== 8'h03 || lives_left !== 4'd2) begin errors++; $display("FAIL ke_inactive got %h/%0d want 03/2", active_mask, lives_left); end
    kid = 3'd0; eid = 3'd1;
    @(negedge clk);
    clear_events();
    checks++; if (active_mask !== 8'h00 || lives_left !== 4'd1) begin errors++; $display("FAIL ke_diff_id got %h/%0d want 00/1", active_mask, lives_left); end
    checks++; if (spawn !== 1'b1 || spawn_id !== 3'd0) begin errors++; $display("FAIL ke_respawn got %0b/%0d want 1/0", spawn, spawn_id); end
    @(negedge clk);
    checks++; if (active_mask !== 8'h01) begin errors++; $display("FAIL ke_respawn_mask got %h want 01", active_mask); end
  endtask

  task automatic test_abort_reset();
    bit ok;
    do_reset();
    s2 = 1'b1;
    for (int s = 0; s < 3; s++) wait_spawn(ok);
    @(negedge clk);
    checks++; if (active_mask !== 8'h07) begin errors++; $display("FAIL ab_mask3 got %h want 07", active_mask); end
    s2 = 1'b0;
    @(negedge clk);
    checks++; if (active_mask !== 8'h00) begin errors++; $display("FAIL ab_cleared got %h want 00", active_mask); end
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checks++; if (spawn !== 1'b0 || d2 !== 1'b0) begin errors++; $display("FAIL ab_quiet%0d got %0b/%0b want 0/0", n, spawn, d2); end
    end
    s1 = 1'b1;
    for (int s = 0; s < 2; s++) begin
      wait_spawn(ok);
      checks++; if (!ok || spawn_id !== 3'(s)) begin errors++; $display("FAIL ab_s1spawn%0d got ok=%0b id=%0d want id %0d", s, ok, spawn_id, s); end
    end
    @(negedge clk);
    checks++; if (active_mask !== 8'h03) begin errors++; $display("FAIL ab_drain_mask got %h want 03", active_mask); end
    reset = 1'b1; s1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({spawn, active_mask, d1, d2, d3, game_over} !== 13'h0 || lives_left !== 4'(LV)) begin
      errors++; $display("FAIL ab_reset got %b lives %0d want 0 lives %0d", {spawn, active_mask, d1, d2, d3, game_over}, lives_left, LV);
    end
  endtask

  task automatic test_game_over();
    bit ok;
    do_reset();
    s1 = 1'b1;
    for (int e = 0; e < 2; e++) begin
      wait_spawn(ok);
      checks++; if (!ok || spawn_id !== 3'd0) begin errors++; $display("FAIL go_spawn%0d got ok=%0b id=%0d want id 0", e, ok, spawn_id); end
      @(negedge clk);
      es = 1'b1; eid = 3'd0;
      @(negedge clk);
      clear_events();
      checks++; if (lives_left !== 4'(LV - 1 - e)) begin errors++; $display("FAIL go_lives%0d got %0d want %0d", e, lives_left, LV - 1 - e); end
    end
    ok = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) begin
      @(negedge clk);
      if (d1 === 1'b1) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL go_s1done got %0b want 1", d1); end
    s1 = 1'b0;
    @(negedge clk);
    s2 = 1'b1;
    wait_spawn(ok);
    checks++; if (!ok || spawn_id !== 3'd0) begin errors++; $display("FAIL go_s2spawn got ok=%0b id=%0d want id 0", ok, spawn_id); end
    @(negedge clk);
    es = 1'b1; eid = 3'd0;
    @(negedge clk);
    clear_events();
    checks++; if (lives_left !== 4'd0 || game_over !== 1'b0) begin errors++; $display("FAIL go_last_escape got %0d/%0b want 0/0", lives_left, game_over); end
    @(negedge clk);
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL go_raise got %0b want 1", game_over); end
    for (int n = 0; n < 8; n++) begin
      s1 = 1'($urandom_range(0, 1)); s2 = 1'($urandom_range(0, 1)); s3 = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++; if ({game_over, spawn, d1, d2, d3} !== 5'b10000 || lives_left !== 4'd0) begin
        errors++; $display("FAIL go_sticky%0d got %b lives %0d want 10000 lives 0", n, {game_over, spawn, d1, d2, d3}, lives_left);
      end
    end
    reset = 1'b1; s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (game_over !== 1'b0 || lives_left !== 4'(LV)) begin errors++; $display("FAIL go_reset got %0b/%0d want 0/%0d", game_over, lives_left, LV); end
  endtask

  task automatic test_random(input int k);
    bit reached;
    logic dk;
    int ki, ei;
    bit kv, ev;
    do_reset();
    m_iv   = (k == 1) ? IV1 : (k == 2) ? IV2 : IV3;
    m_left = (k == 1) ? C1 : (k == 2) ? C2 : C3;
    m_lives = LV;
    for (int i = 0; i < 8; i++) m_act[i] = 1'b0;
    m_spawning = 1'b0; m_drain = 1'b0; m_done = 1'b0;
    m_eta = m_iv + 1;                // state after the edge that samples the stage
    s1 = (k == 1); s2 = (k == 2); s3 = (k == 3);
    reached = 1'b0;
    for (int cyc = 0; cyc < 800 && !reached; cyc++) begin
      @(negedge clk);
      dk = (k == 1) ? d1 : (k == 2) ? d2 : d3;
      checks++; if (active_mask !== m_mask()) begin errors++; $display("FAIL rnd%0d_mask c%0d got %h want %h", k, cyc, active_mask, m_mask()); end
      checks++; if (spawn !== m_spawning) begin errors++; $display("FAIL rnd%0d_spawn c%0d got %0b want %0b", k, cyc, spawn, m_spawning); end
      if (m_spawning) begin
        checks++; if (spawn_id !== 3'(m_lowfree())) begin errors++; $display("FAIL rnd%0d_id c%0d got %0d want %0d", k, cyc, spawn_id, m_lowfree()); end
      end
      checks++; if (lives_left !== 4'(m_lives)) begin errors++; $display("FAIL rnd%0d_lives c%0d got %0d want %0d", k, cyc, lives_left, m_lives); end
      checks++; if (dk !== m_done || game_over !== 1'b0) begin errors++; $display("FAIL rnd%0d_done c%0d got %0b/%0b want %0b/0", k, cyc, dk, game_over, m_done); end
      if (m_done) begin
        reached = 1'b1;
      end else begin
        kv = ($urandom_range(0, 2) == 0) || (m_left == 0 && $urandom_range(0, 1) == 0);
        ev = (m_lives > 1) && ($urandom_range(0, 11) == 0);
        ki = int'($urandom_range(0, 7));
        ei = ($urandom_range(0, 3) == 0) ? ki : int'($urandom_range(0, 7));
        kl = kv; kid = 3'(ki); es = ev; eid = 3'(ei);
        m_step(kv, ki, ev, ei);
      end
    end
    clear_events();
    checks++; if (!reached) begin errors++; $display("FAIL rnd%0d_timeout got no done want done within 800 cycles", k); end
    s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
    @(negedge clk);
    checks++; if ({d1, d2, d3, spawn, active_mask} !== 12'h000) begin errors++; $display("FAIL rnd%0d_release got %b want 0", k, {d1, d2, d3, spawn, active_mask}); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
    clear_events();
    test_reset();
    test_stage1_timing();
    test_stall();
    test_kill_escape();
    test_abort_reset();
    test_game_over();
    for (int r = 0; r < 2; r++) begin
      test_random(1);
      test_random(2);
      test_random(3);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
